// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Reset values live here so the top level and any wrappers agree on them.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 16;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  localparam logic [3:0] WAIT_CNT_RST = 4'd0;
  localparam logic [3:0] WAIT_CNT_SAT = 4'd15;
  localparam port_e      LAST_RST     = PORT_DATA;
  localparam logic       RVALID_RST   = 1'b0;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational grant selection between the fetch and data ports.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin on `last`; otherwise fixed priority with a fetch starvation bound.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic       f_req,
  input  logic       d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  port_e      last,
`else
  input  logic [3:0] wait_cnt,
`endif
  output logic       f_gnt,
  output logic       d_gnt
);

  logic fetch_first;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On contention the port that did not win last time goes first.
  assign fetch_first = (last == PORT_DATA);
`else
  assign fetch_first = (wait_cnt >= 4'(MAX_WAIT));
`endif

  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (f_req && (!d_req || fetch_first)) begin
      f_gnt = 1'b1;
    end else if (d_req) begin
      d_gnt = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store; read data is registered per port.
// Build option MEM_ARB_ROUND_ROBIN_EN replaces fixed priority (with fetch starvation bound) by round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic f_sel;
  logic d_sel;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  port_e last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= LAST_RST;
    end else if (f_gnt) begin
      last <= PORT_FETCH;
    end else if (d_gnt) begin
      last <= PORT_DATA;
    end
  end

  mem_arb_select #(.MAX_WAIT(MAX_WAIT)) u_select (
    .f_req (f_req),
    .d_req (d_req),
    .last  (last),
    .f_gnt (f_sel),
    .d_gnt (d_sel)
  );
`else
  logic [3:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= WAIT_CNT_RST;
    end else if (f_req && !f_gnt) begin
      if (wait_cnt != WAIT_CNT_SAT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end else begin
      wait_cnt <= WAIT_CNT_RST;
    end
  end

  mem_arb_select #(.MAX_WAIT(MAX_WAIT)) u_select (
    .f_req    (f_req),
    .d_req    (d_req),
    .wait_cnt (wait_cnt),
    .f_gnt    (f_sel),
    .d_gnt    (d_sel)
  );
`endif

  // Grants are gated by reset so nothing reaches the memory while reset is held.
  assign f_gnt = reset & f_sel;
  assign d_gnt = reset & d_sel;

  always_comb begin
    mem_addr = '0;
    if (f_gnt) begin
      mem_addr = f_addr;
    end else if (d_gnt) begin
      mem_addr = d_addr;
    end
  end

  assign mem_we    = d_gnt & d_we;
  assign mem_wdata = d_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_rvalid <= RVALID_RST;
      f_rdata  <= '0;
    end else begin
      f_rvalid <= f_gnt;
      if (f_gnt) begin
        f_rdata <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_rvalid <= RVALID_RST;
      d_rdata  <= '0;
    end else begin
      d_rvalid <= d_gnt & ~d_we;
      if (d_gnt && !d_we) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a reference model.
// Honours MEM_ARB_ROUND_ROBIN_EN when the design is built with it.
module tb_mem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        reset;
  logic        f_req;
  logic [9:0]  f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [15:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [9:0]  d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [15:0] d_rdata;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int checks;
  int failures;

  mem_arbiter #(.ADDR_W(10), .DATA_W(16), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_gnt     (f_gnt),
    .f_rvalid  (f_rvalid),
    .f_rdata   (f_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] init_word(input int a);
    logic [15:0] w;
    w = 16'(a * 40503) ^ 16'h5A5A;
    if (a == 0) w = 16'h4014;
    return w;
  endfunction

  // Behavioural single-port memory with a combinational read path.
  logic [15:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr] = mem_wdata;
    end
  end

  // Reference model state
  logic [15:0] ref_mem [0:1023];
  int          m_wait;
  bit          m_last_data;
  logic        e_f_rvalid, e_d_rvalid;
  logic [15:0] e_f_rdata, e_d_rdata;
  logic        eg_f, eg_d;

  task automatic model_reset();
    m_wait      = 0;
    m_last_data = 1'b1;
    e_f_rvalid  = 1'b0;
    e_d_rvalid  = 1'b0;
    e_f_rdata   = 16'h0000;
    e_d_rdata   = 16'h0000;
  endtask

  task automatic model_grants(output logic fg, output logic dg);
    fg = 1'b0;
    dg = 1'b0;
    if (reset) begin
      if (f_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (m_last_data) fg = 1'b1;
        else dg = 1'b1;
`else
        if (m_wait >= MAX_WAIT) fg = 1'b1;
        else dg = 1'b1;
`endif
      end else if (f_req) begin
        fg = 1'b1;
      end else if (d_req) begin
        dg = 1'b1;
      end
    end
  endtask

  // Applies the effect of the rising edge that ends the current cycle.
  task automatic model_advance(input logic fg, input logic dg);
    if (!reset) begin
      model_reset();
    end else begin
      e_f_rvalid = fg;
      if (fg) e_f_rdata = ref_mem[f_addr];
      e_d_rvalid = dg && !d_we;
      if (dg && !d_we) e_d_rdata = ref_mem[d_addr];
      if (dg && d_we) ref_mem[d_addr] = d_wdata;
      if (f_req && !fg) m_wait = (m_wait >= 15) ? 15 : m_wait + 1;
      else m_wait = 0;
      if (fg) m_last_data = 1'b0;
      else if (dg) m_last_data = 1'b1;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; f_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    f_addr = 10'd7; d_addr = 10'd5; d_wdata = 16'hBEEF;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (f_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 10'd0) begin
        failures++;
        $display("FAIL reset_gnt: f_gnt=%b d_gnt=%b mem_we=%b mem_addr=%0d, required all 0", f_gnt, d_gnt, mem_we, mem_addr);
      end
      checks++;
      if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0 || f_rdata !== 16'h0 || d_rdata !== 16'h0) begin
        failures++;
        $display("FAIL reset_rdata: f_rvalid=%b d_rvalid=%b f_rdata=%h d_rdata=%h, required all 0", f_rvalid, d_rvalid, f_rdata, d_rdata);
      end
      model_grants(eg_f, eg_d);
      model_advance(eg_f, eg_d);
      next_cycle();
    end
    reset = 1'b1;
    @(negedge clk);
    model_grants(eg_f, eg_d);
    checks++;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin
`else
    if (f_gnt !== 1'b0 || d_gnt !== 1'b1) begin
`endif
      failures++;
      $display("FAIL first_grant: f_gnt=%b d_gnt=%b after reset release", f_gnt, d_gnt);
    end
    model_advance(eg_f, eg_d);
    next_cycle();
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    model_grants(eg_f, eg_d);
    model_advance(eg_f, eg_d);
    next_cycle();
  endtask

  task automatic test_fetch_read();
    f_req = 1'b1; f_addr = 10'd0; d_req = 1'b0;
    @(negedge clk);
    model_grants(eg_f, eg_d);
    checks++;
    if (f_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_addr !== 10'd0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL fetch_gnt: f_gnt=%b d_gnt=%b mem_addr=%0d mem_we=%b, required 1 0 0 0", f_gnt, d_gnt, mem_addr, mem_we);
    end
    model_advance(eg_f, eg_d);
    next_cycle();
    f_req = 1'b0;
    @(negedge clk);
    checks++;
    if (f_rvalid !== 1'b1 || f_rdata !== 16'h4014) begin
      failures++;
      $display("FAIL fetch_rdata: f_rvalid=%b f_rdata=%h, required 1 4014", f_rvalid, f_rdata);
    end
    model_grants(eg_f, eg_d);
    model_advance(eg_f, eg_d);
    next_cycle();
    @(negedge clk);
    checks++;
    if (f_rvalid !== 1'b0 || f_rdata !== 16'h4014) begin
      failures++;
      $display("FAIL fetch_hold: f_rvalid=%b f_rdata=%h, required 0 4014", f_rvalid, f_rdata);
    end
    model_grants(eg_f, eg_d);
    model_advance(eg_f, eg_d);
    next_cycle();
  endtask

  task automatic test_write_read();
    logic [3:0] exp_we;
    logic [3:0] exp_rv;
    exp_we = 4'b0001;
    exp_rv = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      f_req = 1'b0;
      d_req = (c < 2);
      d_we = (c == 0);
      d_addr = 10'd18;
      d_wdata = (c == 0) ? 16'h0004 : 16'h7777;
      @(negedge clk);
      model_grants(eg_f, eg_d);
      checks++;
      if (mem_we !== exp_we[c] || d_gnt !== d_req || (d_req && mem_addr !== 10'd18)) begin
        failures++;
        $display("FAIL wr_drive c=%0d: mem_we=%b d_gnt=%b mem_addr=%0d, required %b %b 18", c, mem_we, d_gnt, mem_addr, exp_we[c], d_req);
      end
      checks++;
      if (d_rvalid !== exp_rv[c] || (c >= 2 && d_rdata !== 16'h0004)) begin
        failures++;
        $display("FAIL wr_readback c=%0d: d_rvalid=%b d_rdata=%h, required %b 0004", c, d_rvalid, d_rdata, exp_rv[c]);
      end
      model_advance(eg_f, eg_d);
      next_cycle();
    end
  endtask

  task automatic test_priority();
    logic exp_f;
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    f_addr = 10'd33; d_addr = 10'd44;
    for (int c = 0; c < 15; c++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_f = (c % 2 == 0);
`else
      exp_f = (c % (MAX_WAIT + 1) == MAX_WAIT);
`endif
      @(negedge clk);
      model_grants(eg_f, eg_d);
      checks++;
      if (f_gnt !== exp_f || d_gnt !== !exp_f) begin
        failures++;
        $display("FAIL prio c=%0d: f_gnt=%b d_gnt=%b, required %b %b", c, f_gnt, d_gnt, exp_f, !exp_f);
      end
      checks++;
      if (f_rvalid !== e_f_rvalid || f_rdata !== e_f_rdata || d_rvalid !== e_d_rvalid || d_rdata !== e_d_rdata) begin
        failures++;
        $display("FAIL prio_rdata c=%0d: f=%b/%h d=%b/%h, required f=%b/%h d=%b/%h", c, f_rvalid, f_rdata, d_rvalid, d_rdata, e_f_rvalid, e_f_rdata, e_d_rvalid, e_d_rdata);
      end
      model_advance(eg_f, eg_d);
      next_cycle();
    end
    f_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_random();
    logic [9:0]  exp_addr;
    logic        exp_we;
    logic        pg_f, pg_d;
    pg_f = 1'b0;
    pg_d = 1'b0;
    for (int c = 0; c < 500; c++) begin
      // Requests stay stable until granted, with occasional withdrawal.
      if (!f_req || pg_f || $urandom_range(15) == 0) begin
        f_req  = ($urandom_range(3) != 0);
        f_addr = 10'($urandom_range(15));
      end
      if (!d_req || pg_d || $urandom_range(15) == 0) begin
        d_req   = ($urandom_range(3) != 0);
        d_we    = ($urandom_range(2) == 0);
        d_addr  = 10'($urandom_range(15));
        d_wdata = 16'($urandom);
      end
      @(negedge clk);
      model_grants(eg_f, eg_d);
      exp_addr = eg_f ? f_addr : (eg_d ? d_addr : 10'd0);
      exp_we = eg_d && d_we;
      checks++;
      if (f_gnt !== eg_f || d_gnt !== eg_d || mem_addr !== exp_addr || mem_we !== exp_we) begin
        failures++;
        $display("FAIL rand_gnt c=%0d: f_gnt=%b d_gnt=%b mem_addr=%0d mem_we=%b, required %b %b %0d %b", c, f_gnt, d_gnt, mem_addr, mem_we, eg_f, eg_d, exp_addr, exp_we);
      end
      checks++;
      if (f_rvalid !== e_f_rvalid || f_rdata !== e_f_rdata || d_rvalid !== e_d_rvalid || d_rdata !== e_d_rdata) begin
        failures++;
        $display("FAIL rand_rdata c=%0d: f=%b/%h d=%b/%h, required f=%b/%h d=%b/%h", c, f_rvalid, f_rdata, d_rvalid, d_rdata, e_f_rvalid, e_f_rdata, e_d_rvalid, e_d_rdata);
      end
      checks++;
      if (exp_we && mem_wdata !== d_wdata) begin
        failures++;
        $display("FAIL rand_wdata c=%0d: mem_wdata=%h, required %h", c, mem_wdata, d_wdata);
      end
      pg_f = eg_f;
      pg_d = eg_d;
      model_advance(eg_f, eg_d);
      next_cycle();
    end
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    model_grants(eg_f, eg_d);
    model_advance(eg_f, eg_d);
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    f_req = 1'b1; f_addr = 10'd3; d_req = 1'b0;
    @(negedge clk);
    model_grants(eg_f, eg_d);
    checks++;
    if (f_gnt !== 1'b1) begin
      failures++;
      $display("FAIL midrst_gnt: f_gnt=%b, required 1", f_gnt);
    end
    model_advance(eg_f, eg_d);
    next_cycle();
    reset = 1'b0;
    f_req = 1'b0;
    @(negedge clk);
    checks++;
    if (f_rvalid !== 1'b0 || f_rdata !== 16'h0) begin
      failures++;
      $display("FAIL midrst_drop: f_rvalid=%b f_rdata=%h, required 0 0000", f_rvalid, f_rdata);
    end
    model_grants(eg_f, eg_d);
    model_advance(eg_f, eg_d);
    next_cycle();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0 || f_rdata !== 16'h0) begin
        failures++;
        $display("FAIL midrst_after c=%0d: f_rvalid=%b d_rvalid=%b f_rdata=%h, required 0 0 0000", c, f_rvalid, d_rvalid, f_rdata);
      end
      model_grants(eg_f, eg_d);
      model_advance(eg_f, eg_d);
      next_cycle();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    reset = 1'b0;
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    #1;
    test_reset();
    test_fetch_read();
    test_write_read();
    test_priority();
    test_random();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
